mac_dot_sequencer: RTL and testbench
====================================

// Module: mac_dot_sequencer
// PURPOSE
//  Initiator-side controller for the MAC unit: computes one dot product of LEN operand pairs.
//  Takes a job (start + len) and a valid/ready stream of (A,B) pairs, clears the MAC, and
//  pulses mac_en once per pair. Returns the final accumulator on a valid/ready result port.
//  Sits between the operand fetch logic and a MAC instance (drives its rst/en/A/B, reads out).
// PARAMETERS
//  DATA_W   32  operand/result width; sign-magnitude Q21.10 (bit31 sign, [30:10] int, [9:0] frac)
//  LEN_W    8   width of the job length; max LEN = 2**LEN_W-1
//  MAC_LAT  1   cycles from a sampled mac_en to mac_out reflecting that product
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       job request; sampled only in IDLE
//  len        in   LEN_W   pairs in job, captured with start
//  in_valid   in   1       operand pair valid
//  in_ready   out  1       sequencer accepts pair this cycle
//  in_a       in   DATA_W  operand A
//  in_b       in   DATA_W  operand B
//  mac_rst    out  1       active-high clear to MAC
//  mac_en     out  1       one-cycle accumulate strobe to MAC
//  mac_a      out  DATA_W  registered operand A to MAC
//  mac_b      out  DATA_W  registered operand B to MAC
//  mac_out    in   DATA_W  MAC accumulator value
//  res_valid  out  1       result available
//  res_ready  in   1       consumer takes result
//  res_data   out  DATA_W  captured accumulator
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, mac_rst=1 while rst_n low, then 0.
//  Also on reset: mac_en=0, mac_a=mac_b=0, in_ready=0, res_valid=0, res_data=0, counters=0.
//  FSM: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
//  IDLE : start=1 captures len into remaining; next state CLEAR. start in any other state ignored.
//  CLEAR: mac_rst=1 for exactly one cycle. Goes to FEED, or to DRAIN if remaining==0.
//  FEED : in_ready = (remaining!=0), combinational from state/counter only (not from in_valid).
//         Accept on in_valid&in_ready at edge k: mac_a/mac_b<=in_a/in_b, mac_en=1 during cycle k..k+1
//         only, remaining-=1. Back-to-back accepts give back-to-back mac_en pulses.
//         Bubbles (in_valid=0) give mac_en=0; in_a/in_b are don't-care then.
//         When the last pair is accepted: -> DRAIN, with the drain counter loaded to MAC_LAT.
//  DRAIN: waits until the last product is in mac_out: MAC_LAT cycles after the final mac_en
//         cycle (MAC_LAT+1 edges after the last accept). Then res_data<=mac_out, res_valid<=1,
//         go DONE. The len==0 path drains likewise and returns the cleared value 0.
//  DONE : res_valid=1, res_data held stable until res_ready=1. Result transfers on
//         res_valid&res_ready, then res_valid=0 and state=IDLE next cycle.
//         A new start is accepted from IDLE only, so no same-cycle start/transfer overlap.
//  No arithmetic in this block; res_data is bit-exact mac_out (overflow behaviour is the MAC's).
//  mac_a/mac_b hold their last values outside accepts.
// STRUCTURE
//  Shared package tpu_pkg: DATA_W, FRAC_W=10, typedef logic [DATA_W-1:0] fx_t,
//  and enum seq_state_e {IDLE,CLEAR,FEED,DRAIN,DONE}.
//  Single module, no sub-modules. Bench wraps it with a real MAC instance (mac_en->en, mac_rst->rst).
// TESTING
//  1. len=2, pairs (2,3),(5,5) back-to-back -> mac_en 2 consecutive cycles;
//     res_data={0,21'd31,10'd0}.
//  2. len=2, pairs (-3,4),(2,3) with 3-cycle bubble between -> exactly 2 mac_en pulses;
//     res_data={1,21'd6,10'd0}.
//  3. len=2, (0.5,0.5),(0.25,1.5): {0,21'd0,10'b1000000000}... ->
//     res_data={0,21'd0,10'b1010000000} (0.625).
//  4. len=0 -> one mac_rst cycle, zero mac_en, res_data=0, res_valid within 3+MAC_LAT cycles of start.
//  5. res_ready held low 5 cycles in DONE, start pulsed -> res_data stable, start ignored, busy=1;
//     res_ready=1 -> IDLE next cycle.
//  6. rst_n low mid-FEED after 1 of 3 pairs -> all outputs at reset values immediately;
//     new len=1 job (7,1) gives {0,21'd7,10'd0}.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types for the MAC datapath: fixed-point word and sequencer states.
package tpu_pkg;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 10;

    // Sign-magnitude Q21.10: bit 31 sign, [30:10] integer, [9:0] fraction.
    typedef logic [DATA_W-1:0] fx_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/mac_dot_sequencer.sv
// Dot-product job controller: clears the MAC, strobes one accumulate per
// accepted operand pair, waits out the MAC latency and presents the result.
module mac_dot_sequencer
    import tpu_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_a,
    input  logic [DATA_W-1:0] i_in_b,
    output logic              o_mac_rst,
    output logic              o_mac_en,
    output logic [DATA_W-1:0] o_mac_a,
    output logic [DATA_W-1:0] o_mac_b,
    input  logic [DATA_W-1:0] i_mac_out,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [DATA_W-1:0] o_res_data,
    output logic              o_busy
);

    localparam int DRAIN_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

    seq_state_e         r_state;
    seq_state_e         w_state_nx;
    logic [LEN_W-1:0]   r_remaining;
    logic [DRAIN_W-1:0] r_drain;
    logic [DATA_W-1:0]  r_mac_a;
    logic [DATA_W-1:0]  r_mac_b;
    logic               r_mac_en;
    logic               r_mac_rst;
    logic               r_res_valid;
    logic [DATA_W-1:0]  r_res_data;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_last_accept;
    logic               w_load_drain;
    logic               w_capture;

    // Handshake and next-state decode; in_ready depends only on state and counter.
    always_comb begin
        w_state_nx    = r_state;
        w_in_ready    = (r_state == FEED) && (r_remaining != {LEN_W{1'b0}});
        w_accept      = w_in_ready && i_in_valid;
        w_last_accept = w_accept && (r_remaining == {{(LEN_W-1){1'b0}}, 1'b1});
        w_load_drain  = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nx = CLEAR;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            CLEAR: begin
                w_load_drain = (r_remaining == {LEN_W{1'b0}});
                if (r_remaining == {LEN_W{1'b0}}) begin
                    w_state_nx = DRAIN;
                end else begin
                    w_state_nx = FEED;
                end
            end
            FEED: begin
                w_load_drain = w_last_accept;
                if (w_last_accept) begin
                    w_state_nx = DRAIN;
                end else begin
                    w_state_nx = FEED;
                end
            end
            DRAIN: begin
                if (r_drain == {DRAIN_W{1'b0}}) begin
                    w_capture  = 1'b1;
                    w_state_nx = DONE;
                end else begin
                    w_state_nx = DRAIN;
                end
            end
            DONE: begin
                if (i_res_ready) begin
                    w_state_nx = IDLE;
                end else begin
                    w_state_nx = DONE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Counters, MAC drive and result capture; MAC clear is held during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= {LEN_W{1'b0}};
            r_drain     <= {DRAIN_W{1'b0}};
            r_mac_a     <= {DATA_W{1'b0}};
            r_mac_b     <= {DATA_W{1'b0}};
            r_mac_en    <= 1'b0;
            r_mac_rst   <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_data  <= {DATA_W{1'b0}};
        end else begin
            r_mac_en    <= w_accept;
            r_mac_rst   <= (w_state_nx == CLEAR);
            r_res_valid <= (w_state_nx == DONE);
            if (w_accept) begin
                r_mac_a <= i_in_a;
                r_mac_b <= i_in_b;
            end else begin
                r_mac_a <= r_mac_a;
                r_mac_b <= r_mac_b;
            end
            if ((r_state == IDLE) && i_start) begin
                r_remaining <= i_len;
            end else if (w_accept) begin
                r_remaining <= r_remaining - {{(LEN_W-1){1'b0}}, 1'b1};
            end else begin
                r_remaining <= r_remaining;
            end
            if (w_load_drain) begin
                r_drain <= DRAIN_W'(MAC_LAT);
            end else if ((r_state == DRAIN) && (r_drain != {DRAIN_W{1'b0}})) begin
                r_drain <= r_drain - {{(DRAIN_W-1){1'b0}}, 1'b1};
            end else begin
                r_drain <= r_drain;
            end
            if (w_capture) begin
                r_res_data <= i_mac_out;
            end else begin
                r_res_data <= r_res_data;
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_mac_rst   = r_mac_rst;
    assign o_mac_en    = r_mac_en;
    assign o_mac_a     = r_mac_a;
    assign o_mac_b     = r_mac_b;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: wraps it with a behavioural sign-magnitude MAC
// and checks results against a plain-arithmetic dot-product reference.
module tb_mac_dot_sequencer;

    localparam int MAC_LAT = 1;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [7:0]  i_len;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [31:0] i_in_a;
    logic [31:0] i_in_b;
    logic        o_mac_rst;
    logic        o_mac_en;
    logic [31:0] o_mac_a;
    logic [31:0] o_mac_b;
    logic [31:0] mac_out;
    logic        o_res_valid;
    logic        i_res_ready;
    logic [31:0] o_res_data;
    logic        o_busy;

    int n_chk  = 0;
    int n_pass = 0;
    int en_cnt = 0;
    int rst_cnt = 0;
    int run = 0;
    int max_run = 0;
    int ja [8];
    int jb [8];
    longint acc;

    mac_dot_sequencer #(.LEN_W(8), .MAC_LAT(MAC_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_len      (i_len),
        .i_in_valid (i_in_valid),
        .o_in_ready (o_in_ready),
        .i_in_a     (i_in_a),
        .i_in_b     (i_in_b),
        .o_mac_rst  (o_mac_rst),
        .o_mac_en   (o_mac_en),
        .o_mac_a    (o_mac_a),
        .o_mac_b    (o_mac_b),
        .i_mac_out  (mac_out),
        .o_res_valid(o_res_valid),
        .i_res_ready(i_res_ready),
        .o_res_data (o_res_data),
        .o_busy     (o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] enc(input longint v);
        longint m;
        logic [31:0] r;
        m = (v < 0) ? -v : v;
        r = {((v < 0) ? 1'b1 : 1'b0), m[30:0]};
        return r;
    endfunction

    // Sign-magnitude product with fraction truncated (toward zero).
    function automatic longint mac_prod(input logic [31:0] a, input logic [31:0] b);
        longint ma;
        longint mb;
        longint p;
        ma = longint'({1'b0, a[30:0]});
        mb = longint'({1'b0, b[30:0]});
        p  = (ma * mb) >>> 10;
        return (a[31] ^ b[31]) ? -p : p;
    endfunction

    // Behavioural MAC, one cycle latency.
    always @(posedge clk) begin
        if (o_mac_rst) acc <= 64'sd0;
        else if (o_mac_en) acc <= acc + mac_prod(o_mac_a, o_mac_b);
    end
    assign mac_out = enc(acc);

    // Strobe monitor.
    always @(posedge clk) begin
        if (o_mac_en) begin
            en_cnt = en_cnt + 1;
            run = run + 1;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (o_mac_rst) rst_cnt = rst_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_mac_en"},  64'(o_mac_en), 64'd0);
        check_val({tag, "_mac_rst"}, 64'(o_mac_rst), 64'd1);
        check_val({tag, "_in_rdy"},  64'(o_in_ready), 64'd0);
        check_val({tag, "_resv"},    64'(o_res_valid), 64'd0);
        check_val({tag, "_resd"},    64'(o_res_data), 64'd0);
        check_val({tag, "_busy"},    64'(o_busy), 64'd0);
        check_val({tag, "_mac_ab"},  64'({o_mac_a, o_mac_b}), 64'd0);
    endtask

    // Feed pairs ja/jb with the given bubble gap between them.
    task automatic feed_pairs(input int n, input int gap, input string tag);
        int t;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    i_in_valid = 1'b0;
                    i_in_a = $urandom;
                    i_in_b = $urandom;
                    @(negedge clk);
                end
            end
            i_in_valid = 1'b1;
            i_in_a = enc(longint'(ja[i]));
            i_in_b = enc(longint'(jb[i]));
            t = 0;
            while (!o_in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            check_val({tag, "_in_ready"}, 64'(o_in_ready), 64'd1);
            @(negedge clk);
        end
        i_in_valid = 1'b0;
    endtask

    task automatic run_job(input int n, input int gap, input int hold, input string tag);
        longint exp_v;
        logic [31:0] exp_w;
        int t;
        exp_v = 0;
        for (int i = 0; i < n; i++) exp_v += (longint'(ja[i]) * longint'(jb[i])) / 1024;
        exp_w = enc(exp_v);
        en_cnt = 0; rst_cnt = 0; run = 0; max_run = 0;
        i_start = 1'b1;
        i_len = 8'(n);
        @(negedge clk);
        i_start = 1'b0;
        check_val({tag, "_busy"}, 64'(o_busy), 64'd1);
        feed_pairs(n, gap, tag);
        t = 0;
        while (!o_res_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        check_val({tag, "_resv"}, 64'(o_res_valid), 64'd1);
        check_val({tag, "_resd"}, 64'(o_res_data), 64'(exp_w));
        if (n == 0) check_val({tag, "_lat"}, 64'((t + 1) <= (3 + MAC_LAT)), 64'd1);
        check_val({tag, "_en_cnt"}, 64'(en_cnt), 64'(n));
        check_val({tag, "_rst_cnt"}, 64'(rst_cnt), 64'd1);
        if (gap == 0 && n > 0) check_val({tag, "_b2b"}, 64'(max_run), 64'(n));
        if (n > 0) check_val({tag, "_mac_a_hold"}, 64'(o_mac_a), 64'(enc(longint'(ja[n-1]))));
        for (int h = 0; h < hold; h++) begin
            i_res_ready = 1'b0;
            i_start = (h == 1) ? 1'b1 : 1'b0;
            @(negedge clk);
            check_val({tag, "_hold_d"}, 64'(o_res_data), 64'(exp_w));
            check_val({tag, "_hold_busy"}, 64'(o_busy), 64'd1);
        end
        i_start = 1'b0;
        i_res_ready = 1'b1;
        @(negedge clk);
        i_res_ready = 1'b0;
        check_val({tag, "_idle"}, 64'(o_busy), 64'd0);
        check_val({tag, "_resv_lo"}, 64'(o_res_valid), 64'd0);
        @(negedge clk);
        check_val({tag, "_stay_idle"}, 64'({o_busy, o_mac_rst}), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_len = 8'd0; i_in_valid = 1'b0;
        i_in_a = 32'd0; i_in_b = 32'd0; i_res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_reset_mac_rst", 64'(o_mac_rst), 64'd0);

        // (2,3),(5,5) back-to-back -> 31
        ja[0] = 2 * 1024; jb[0] = 3 * 1024; ja[1] = 5 * 1024; jb[1] = 5 * 1024;
        run_job(2, 0, 0, "t1");
        check_val("t1_const", 64'(o_res_data), 64'({1'b0, 21'd31, 10'd0}));
        // (-3,4),(2,3) with 3-cycle bubble -> -6
        ja[0] = -3 * 1024; jb[0] = 4 * 1024; ja[1] = 2 * 1024; jb[1] = 3 * 1024;
        run_job(2, 3, 0, "t2");
        check_val("t2_const", 64'(o_res_data), 64'({1'b1, 21'd6, 10'd0}));
        // fractions, plus held result with start pulse in DONE
        ja[0] = 512; jb[0] = 512; ja[1] = 256; jb[1] = 1536;
        run_job(2, 0, 5, "t3");
        check_val("t3_const", 64'(o_res_data), 64'({1'b0, 21'd0, 10'b1010000000}));
        // empty job
        run_job(0, 0, 0, "t4");

        // reset mid-FEED after one of three pairs
        ja[0] = 1024; jb[0] = 1024;
        i_start = 1'b1; i_len = 8'd3;
        @(negedge clk);
        i_start = 1'b0;
        feed_pairs(1, 0, "t6");
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ja[0] = 7 * 1024; jb[0] = 1024;
        run_job(1, 0, 0, "t6_job");
        check_val("t6_const", 64'(o_res_data), 64'({1'b0, 21'd7, 10'd0}));

        // randomized jobs
        for (int j = 0; j < 8; j++) begin
            int n;
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++) begin
                ja[i] = int'($urandom_range(0, 8192)) - 4096;
                jb[i] = int'($urandom_range(0, 8192)) - 4096;
            end
            run_job(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), $sformatf("rnd%0d", j));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
